// File: rtl/frame_timer_if.sv
// Control/readout bundle between the game FSM, the frame timer and the HUD/score logic.
interface frame_timer_if #(
  parameter int SEC_W = 7,
  parameter int SUB_W = 6
);
  logic             enable;
  logic             pause;
  logic             periodic;
  logic [SEC_W-1:0] load_secs;
  logic             frame_tick;
  logic             done;
  logic             busy;
  logic [SEC_W-1:0] secs_left;
  logic [SUB_W-1:0] sub_left;

  modport master (
    output enable, pause, periodic, load_secs,
    input  frame_tick, done, busy, secs_left, sub_left
  );

  modport slave (
    input  enable, pause, periodic, load_secs,
    output frame_tick, done, busy, secs_left, sub_left
  );
endinterface

// File: rtl/frame_timer.sv
// Game-time countdown: prescaler makes frame ticks, seconds/frames down-counter
// signals expiry, with one-shot/periodic mode, pause and abort.
module frame_timer #(
  parameter int DELAY_CYCLES = 833334,
  parameter int FPS          = 60,
  parameter int SEC_W        = 7,
  parameter int SUB_W        = 6
) (
  input  logic         clk,
  input  logic         resetn,
  frame_timer_if.slave bus
);
  localparam int PW = $clog2(DELAY_CYCLES);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DELAY_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_FULL = SUB_W'(FPS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t           state, nxt;
  logic [PW-1:0]    presc, presc_n;
  logic [SEC_W-1:0] secs, secs_n, ld_q, ld_n;
  logic [SUB_W-1:0] sub, sub_n;
  logic             per_q, per_n;
  logic             tick, tick_n, done, done_n, busy, busy_n;
  logic             wrap;

  assign wrap = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      presc <= '0;
      secs  <= '0;
      sub   <= '0;
      ld_q  <= '0;
      per_q <= 1'b0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nxt;
      presc <= presc_n;
      secs  <= secs_n;
      sub   <= sub_n;
      ld_q  <= ld_n;
      per_q <= per_n;
      tick  <= tick_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    nxt     = state;
    presc_n = presc;
    secs_n  = secs;
    sub_n   = sub;
    ld_n    = ld_q;
    per_n   = per_q;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          presc_n = '0;
          per_n   = bus.periodic;
          ld_n    = bus.load_secs;
          if (bus.load_secs == '0) begin
            // zero-length countdown expires immediately, whatever the mode
            nxt    = EXPIRED;
            done_n = 1'b1;
            secs_n = '0;
            sub_n  = '0;
          end else begin
            nxt    = RUN;
            secs_n = bus.load_secs;
            sub_n  = SUB_FULL;
          end
        end
      end
      RUN: begin
        presc_n = wrap ? '0 : presc + PW'(1);
        if (wrap) begin
          tick_n = 1'b1;
          if (sub > SUB_W'(1)) begin
            sub_n = sub - SUB_W'(1);
          end else if (secs > SEC_W'(1)) begin
            secs_n = secs - SEC_W'(1);
            sub_n  = SUB_FULL;
          end else begin
            done_n = 1'b1;
            if (per_q) begin
              secs_n = ld_q;
              sub_n  = SUB_FULL;
            end else begin
              nxt     = EXPIRED;
              presc_n = '0;
              secs_n  = '0;
              sub_n   = '0;
            end
          end
        end
        // this edge still counts; freezing starts on the next one
        if (bus.pause && nxt == RUN) nxt = PAUSED;
      end
      PAUSED: begin
        if (!bus.pause) nxt = RUN;
      end
      default: ;
    endcase
    if (!bus.enable) begin
      nxt     = IDLE;
      presc_n = '0;
      secs_n  = '0;
      sub_n   = '0;
      tick_n  = 1'b0;
      done_n  = 1'b0;
    end
    busy_n = (nxt == RUN) || (nxt == PAUSED);
  end

  assign bus.frame_tick = tick;
  assign bus.done       = done;
  assign bus.busy       = busy;
  assign bus.secs_left  = secs;
  assign bus.sub_left   = sub;
endmodule
